// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store byte enables and merge into the old word,
// load lane selection with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wmerge_o,
  output logic [31:0] rdata_o
);

  logic [31:0] wlane;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    unique case (addr_lo_i)
      2'd0:    rbyte = rword_i[7:0];
      2'd1:    rbyte = rword_i[15:8];
      2'd2:    rbyte = rword_i[23:16];
      default: rbyte = rword_i[31:24];
    endcase
    rhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  always_comb begin
    be_o    = 4'b1111;
    wlane   = wdata_i;
    rdata_o = rword_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wlane   = {4{wdata_i[7:0]}};
        rdata_o = uns_i ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wlane   = {2{wdata_i[15:0]}};
        rdata_o = uns_i ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      default: ;
    endcase
  end

  // Unselected lanes keep the word's previous contents.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wmerge_o[8*i +: 8] = be_o[i] ? wlane[8*i +: 8] : rword_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: valid/ready request, programmable wait states, one-cycle
// response pulse, word-organised RAM with byte-lane stores and extended loads.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] BYTES = 32'(DEPTH * 4);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        enter_resp;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  logic        cur_we, cur_uns, cur_err;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;
  logic [31:0] rword, wmerge, ld_data;
  logic [3:0]  be_unused;

  logic [31:0] mem [DEPTH];

  // With zero wait states RESP is entered on the acceptance edge, so the live
  // request is used there; otherwise the latched copy is.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we = req_we; cur_uns = req_unsigned; cur_size = req_size;
      cur_addr = req_addr; cur_wdata = req_wdata;
    end else begin
      cur_we = we_q; cur_uns = uns_q; cur_size = size_q;
      cur_addr = addr_q; cur_wdata = wdata_q;
    end
    cur_err = (cur_size == SZ_ILL) ||
              (cur_size == SZ_HALF && cur_addr[0]) ||
              (cur_size == SZ_WORD && cur_addr[1:0] != 2'b00) ||
              (cur_addr >= BYTES);
  end

  assign rword = mem[cur_addr[AW+1:2]];

  dmem_lane_align u_align (
    .size_i    (cur_size),
    .addr_lo_i (cur_addr[1:0]),
    .uns_i     (cur_uns),
    .wdata_i   (cur_wdata),
    .rword_i   (rword),
    .be_o      (be_unused),
    .wmerge_o  (wmerge),
    .rdata_o   (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        cnt_d = 4'd0;
        if (WAIT_STATES == 0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == 4'(WAIT_STATES - 1)) begin
        state_d    = RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= enter_resp;
      rsp_err_q   <= enter_resp && cur_err;
      rsp_rdata_q <= (enter_resp && !cur_err && !cur_we) ? ld_data : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // RAM is never cleared; an asserted reset suppresses a pending write.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && cur_we && !cur_err) begin
      mem[cur_addr[AW+1:2]] <= wmerge;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed load/store cases plus a
// randomised section checked against a small memory model.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int WS    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          rsp_cnt = 0;
  logic        prev_vld = 1'b0;
  logic [31:0] mdl [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && rsp_valid) begin
      rsp_cnt++;
      if (prev_vld) check_eq("rsp_pulse_width", 32'd2, 32'd1);
      if (sb_q.size() == 0) begin
        check_eq("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq({e.tag, "_rdata"}, rsp_rdata, e.rdata);
        check_eq({e.tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
    prev_vld = rsp_valid;
  end

  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int guard;
    int lat;
    exp_t e;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check_eq({tag, "_ready_timeout"}, 32'd0, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    e.tag = tag; e.rdata = exp_rdata; e.err = exp_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the request must already be latched.
    req_valid = 1'b0; req_we = ~we; req_size = 2'($urandom);
    req_unsigned = ~uns; req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) check_eq({tag, "_rsp_timeout"}, 32'd0, 32'd1);
    else check_eq({tag, "_latency"}, 32'(lat), 32'(WS + 1));
  endtask

  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    int          lane;
    err = (size == 2'b11) || (size == 2'b01 && a[0]) ||
          (size == 2'b10 && a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    rd = 32'd0;
    if (!err) begin
      lane = int'(a[1:0]);
      w = mdl[(a - 32'h40) >> 2];
      if (we) begin
        if (size == 2'b00) w[8*lane +: 8] = wd[7:0];
        else if (size == 2'b01) w[16*(lane/2) +: 16] = wd[15:0];
        else w = wd;
        mdl[(a - 32'h40) >> 2] = w;
      end else if (size == 2'b00) begin
        b = w[8*lane +: 8];
        rd = uns ? {24'd0, b} : {{24{b[7]}}, b};
      end else if (size == 2'b01) begin
        h = w[16*(lane/2) +: 16];
        rd = uns ? {16'd0, h} : {{16{h[15]}}, h};
      end else begin
        rd = w;
      end
    end
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic        err, we, uns;
    logic [1:0]  sz;
    int          cnt0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ready", {31'd0, req_ready}, 32'd1);
    check_eq("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    access("sw_10",  1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    access("lw_10",  0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    access("sw_10z", 1, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0);
    access("sb_11",  1, 2'b00, 0, 32'h11, 32'h80, 32'h0, 0);
    access("lb_11",  0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFF80, 0);
    access("lbu_11", 0, 2'b00, 1, 32'h11, 32'h0, 32'h00000080, 0);
    access("lw_10b", 0, 2'b10, 1, 32'h10, 32'h0, 32'h00008000, 0);

    access("sw_20",  1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0);
    access("sh_22",  1, 2'b01, 0, 32'h22, 32'h0000BEEF, 32'h0, 0);
    access("lh_22",  0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFFBEEF, 0);
    access("lhu_22", 0, 2'b01, 1, 32'h22, 32'h0, 32'h0000BEEF, 0);
    access("lh_23",  0, 2'b01, 0, 32'h23, 32'h0, 32'h0, 1);
    access("lw_20",  0, 2'b10, 0, 32'h20, 32'h0, 32'hBEEF3344, 0);

    access("sw_00",    1, 2'b10, 0, 32'h00, 32'hA5A5A5A5, 32'h0, 0);
    access("sw_04",    1, 2'b10, 0, 32'h04, 32'h5A5A5A5A, 32'h0, 0);
    access("sw_400",   1, 2'b10, 0, 32'h400, 32'h01010101, 32'h0, 1);
    access("lw_00a",   0, 2'b10, 0, 32'h00, 32'h0, 32'hA5A5A5A5, 0);
    access("ssz11_00", 1, 2'b11, 0, 32'h00, 32'h02020202, 32'h0, 1);
    access("lw_00b",   0, 2'b10, 0, 32'h00, 32'h0, 32'hA5A5A5A5, 0);
    access("sw_06",    1, 2'b10, 0, 32'h06, 32'h03030303, 32'h0, 1);
    access("lw_04",    0, 2'b10, 0, 32'h04, 32'h0, 32'h5A5A5A5A, 0);
    access("lsz11_04", 0, 2'b11, 0, 32'h04, 32'h0, 32'h0, 1);

    access("sw_30", 1, 2'b10, 0, 32'h30, 32'hCAFEF00D, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 32'h30; req_wdata = 32'h12345678;
    cnt0 = rsp_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_ready", {31'd0, req_ready}, 32'd1);
    check_eq("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("abort_no_rsp", 32'(rsp_cnt), 32'(cnt0));
    access("lw_30", 0, 2'b10, 0, 32'h30, 32'h0, 32'hCAFEF00D, 0);

    for (int i = 0; i < 16; i++) begin
      mdl[i] = $urandom;
      access("rnd_init", 1, 2'b10, 0, 32'h40 + 32'(4*i), mdl[i], 32'h0, 0);
    end
    for (int i = 0; i < 24; i++) begin
      a   = 32'h40 + 32'($urandom_range(0, 63));
      sz  = 2'($urandom_range(0, 3));
      we  = 1'($urandom);
      uns = 1'($urandom);
      wd  = $urandom;
      model(we, sz, uns, a, wd, rd, err);
      access("rnd", we, sz, uns, a, wd, rd, err);
    end

    repeat (4) @(negedge clk);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
